// File: rtl/piano_pkg.sv
// Shared constants, state encodings and tempo codes
// for the piano melody/harmony player pipeline.
package piano_pkg;

  localparam int SONG_LEN = 168;
  localparam logic [7:0] REST_IDX = 8'd255;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam logic [1:0] TEMPO_X1   = 2'b00;
  localparam logic [1:0] TEMPO_X2   = 2'b01;
  localparam logic [1:0] TEMPO_X4   = 2'b10;
  localparam logic [1:0] TEMPO_HALF = 2'b11;

  function automatic int unsigned beat_period(
    input logic [1:0]  sel,
    input int unsigned ticks
  );
    unique case (sel)
      TEMPO_X1: beat_period = ticks;
      TEMPO_X2: beat_period = ticks >> 1;
      TEMPO_X4: beat_period = ticks >> 2;
      default:  beat_period = ticks << 1;
    endcase
  endfunction

endpackage

// File: rtl/tempo_prescaler.sv
// Beat-rate prescaler: counts 0..last while enabled,
// pulses tick on the terminal count and wraps to 0.
module tempo_prescaler #(
  parameter int W = 25
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         enable,
  input  logic         clear,
  input  logic [W-1:0] last,
  output logic         tick
);

  logic [W-1:0] cnt;

  assign tick = enable && (cnt == last);

  always_ff @(posedge clk) begin
    if (reset || clear) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/beat_sequencer.sv
// Beat index generator: play/pause/stop FSM stepping
// the song index at the selected tempo.
module beat_sequencer #(
  parameter int         BEAT_TICKS = 6_250_000,
  parameter int         SONG_LEN   = piano_pkg::SONG_LEN,
  parameter logic [7:0] REST_IDX   = piano_pkg::REST_IDX,
  parameter bit         LOOP       = 1'b0,
  parameter int         PRE_W      = 25
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       play,
  input  logic       pause,
  input  logic       stop,
  input  logic [1:0] tempo_sel,
  output logic [7:0] beats,
  output logic       beat_tick,
  output logic       playing,
  output logic       done
);

  import piano_pkg::*;

  state_t           state;
  logic [PRE_W-1:0] last_q;
  logic [PRE_W-1:0] sel_last;
  logic             pre_en;
  logic             pre_clr;
  logic             adv;
  logic             start;

  assign sel_last = PRE_W'(beat_period(tempo_sel, BEAT_TICKS) - 1);
  assign start    = play && (state == IDLE || state == DONE);
  assign pre_en   = (state == PLAY) && !stop && !pause;
  assign pre_clr  = stop || start;

  tempo_prescaler #(
    .W(PRE_W)
  ) u_pre (
    .clk    (CLOCK_50),
    .reset  (reset),
    .enable (pre_en),
    .clear  (pre_clr),
    .last   (last_q),
    .tick   (adv)
  );

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state     <= IDLE;
      beats     <= REST_IDX;
      beat_tick <= 1'b0;
      playing   <= 1'b0;
      done      <= 1'b0;
      last_q    <= PRE_W'(BEAT_TICKS - 1);
    end else begin
      beat_tick <= 1'b0;
      if (stop) begin
        state   <= IDLE;
        beats   <= REST_IDX;
        playing <= 1'b0;
        done    <= 1'b0;
      end else begin
        unique case (state)
          IDLE, DONE: begin
            if (play) begin
              state   <= PLAY;
              beats   <= 8'd0;
              playing <= 1'b1;
              done    <= 1'b0;
              last_q  <= sel_last;
            end
          end
          PLAY: begin
            if (pause) begin
              state   <= PAUSE;
              playing <= 1'b0;
            end else if (adv) begin
              // tempo only changes on beat boundaries
              last_q <= sel_last;
              if (beats == 8'(SONG_LEN - 1)) begin
                if (LOOP) begin
                  beats     <= 8'd0;
                  beat_tick <= 1'b1;
                end else begin
                  state   <= DONE;
                  beats   <= REST_IDX;
                  playing <= 1'b0;
                  done    <= 1'b1;
                end
              end else begin
                beats     <= beats + 8'd1;
                beat_tick <= 1'b1;
              end
            end
          end
          PAUSE: begin
            if (play) begin
              state   <= PLAY;
              playing <= 1'b1;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_beat_sequencer.sv
// Bench for beat_sequencer: directed scenarios plus
// randomized control pulses against a behavioural model.
module tb_beat_sequencer;

  localparam int LEN = 6;
  localparam int M_IDLE = 0, M_PLAY = 1, M_PAUSE = 2, M_DONE = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       play = 1'b0;
  logic       pause = 1'b0;
  logic       stop = 1'b0;
  logic [1:0] tempo = 2'b00;

  logic [7:0] b0, b1;
  logic       t0, t1, p0, p1, d0, d1;

  int n_checks = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  beat_sequencer #(
    .BEAT_TICKS(4), .SONG_LEN(LEN), .REST_IDX(8'd255),
    .LOOP(1'b0), .PRE_W(4)
  ) dut0 (
    .CLOCK_50(clk), .reset(reset), .play(play), .pause(pause),
    .stop(stop), .tempo_sel(tempo), .beats(b0), .beat_tick(t0),
    .playing(p0), .done(d0)
  );

  beat_sequencer #(
    .BEAT_TICKS(4), .SONG_LEN(LEN), .REST_IDX(8'd255),
    .LOOP(1'b1), .PRE_W(4)
  ) dut1 (
    .CLOCK_50(clk), .reset(reset), .play(play), .pause(pause),
    .stop(stop), .tempo_sel(tempo), .beats(b1), .beat_tick(t1),
    .playing(p1), .done(d1)
  );

  // Reference: mode, beat index, cycles spent in beat, beat length
  int m_mode[2] = '{M_IDLE, M_IDLE};
  int m_idx[2]  = '{0, 0};
  int m_el[2]   = '{0, 0};
  int m_per[2]  = '{4, 4};
  bit m_tick[2] = '{1'b0, 1'b0};

  function automatic int beat_len(input logic [1:0] s);
    case (s)
      2'b00:   return 4;
      2'b01:   return 2;
      2'b10:   return 1;
      default: return 8;
    endcase
  endfunction

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      m_tick[k] = 1'b0;
      if (reset) begin
        m_mode[k] = M_IDLE;
        m_el[k] = 0;
        m_per[k] = 4;
      end else if (stop) begin
        m_mode[k] = M_IDLE;
      end else begin
        case (m_mode[k])
          M_IDLE, M_DONE: if (play) begin
            m_mode[k] = M_PLAY;
            m_idx[k] = 0;
            m_el[k] = 0;
            m_per[k] = beat_len(tempo);
          end
          M_PLAY: if (pause) begin
            m_mode[k] = M_PAUSE;
          end else begin
            m_el[k]++;
            if (m_el[k] == m_per[k]) begin
              m_el[k] = 0;
              m_per[k] = beat_len(tempo);
              if (m_idx[k] == LEN - 1) begin
                if (k == 1) begin
                  m_idx[k] = 0;
                  m_tick[k] = 1'b1;
                end else begin
                  m_mode[k] = M_DONE;
                end
              end else begin
                m_idx[k]++;
                m_tick[k] = 1'b1;
              end
            end
          end
          default: if (play) m_mode[k] = M_PLAY;
        endcase
      end
    end
  end

  function automatic logic [10:0] model_vec(input int k);
    logic [7:0] bi;
    bi = (m_mode[k] == M_PLAY || m_mode[k] == M_PAUSE) ? 8'(m_idx[k]) : 8'd255;
    return {bi, m_tick[k], m_mode[k] == M_PLAY, m_mode[k] == M_DONE};
  endfunction

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cyc();
    n_checks++;
    if (b0 !== 8'd255) begin
      n_fail++; $display("FAIL reset_beats got=%0d exp=255", b0);
    end
    n_checks++;
    if ({t0, p0, d0} !== 3'b000) begin
      n_fail++; $display("FAIL reset_flags got=%b exp=000", {t0, p0, d0});
    end
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_play_done();
    play = 1'b1; cyc(); play = 1'b0;
    n_checks++;
    if (b0 !== 8'd0 || p0 !== 1'b1) begin
      n_fail++; $display("FAIL play_start got=%0d/%b exp=0/1", b0, p0);
    end
    for (int k = 1; k <= LEN; k++) begin
      repeat (3) cyc();
      n_checks++;
      if (b0 !== 8'(k - 1) || t0 !== 1'b0) begin
        n_fail++;
        $display("FAIL beat_hold got=%0d/%b exp=%0d/0", b0, t0, k - 1);
      end
      cyc();
      n_checks++;
      if (b0 !== ((k == LEN) ? 8'd255 : 8'(k)) || t0 !== (k < LEN)) begin
        n_fail++;
        $display("FAIL beat_adv got=%0d/%b exp_k=%0d", b0, t0, k);
      end
    end
    n_checks++;
    if (d0 !== 1'b1 || p0 !== 1'b0) begin
      n_fail++; $display("FAIL done_flag got=%b/%b exp=1/0", d0, p0);
    end
  endtask

  task automatic test_loop();
    stop = 1'b1; cyc(); stop = 1'b0;
    n_checks++;
    if (b1 !== 8'd255 || p1 !== 1'b0) begin
      n_fail++; $display("FAIL loop_stop got=%0d/%b exp=255/0", b1, p1);
    end
    play = 1'b1; cyc(); play = 1'b0;
    repeat (4 * LEN - 1) cyc();
    n_checks++;
    if (b1 !== 8'(LEN - 1) || t1 !== 1'b0) begin
      n_fail++; $display("FAIL loop_last got=%0d/%b exp=5/0", b1, t1);
    end
    cyc();
    n_checks++;
    if (b1 !== 8'd0 || t1 !== 1'b1 || p1 !== 1'b1 || d1 !== 1'b0) begin
      n_fail++;
      $display("FAIL loop_wrap got=%0d/%b/%b/%b exp=0/1/1/0", b1, t1, p1, d1);
    end
  endtask

  task automatic test_pause();
    stop = 1'b1; cyc(); stop = 1'b0;
    play = 1'b1; cyc(); play = 1'b0;
    repeat (8) cyc();
    n_checks++;
    if (b0 !== 8'd2 || t0 !== 1'b1) begin
      n_fail++; $display("FAIL pause_beat2 got=%0d/%b exp=2/1", b0, t0);
    end
    repeat (2) cyc();
    pause = 1'b1; cyc(); pause = 1'b0;
    repeat (10) cyc();
    n_checks++;
    if (b0 !== 8'd2 || p0 !== 1'b0) begin
      n_fail++; $display("FAIL pause_hold got=%0d/%b exp=2/0", b0, p0);
    end
    play = 1'b1; cyc(); play = 1'b0;
    cyc();
    n_checks++;
    if (b0 !== 8'd2 || p0 !== 1'b1) begin
      n_fail++; $display("FAIL pause_resume got=%0d/%b exp=2/1", b0, p0);
    end
    cyc();
    n_checks++;
    if (b0 !== 8'd3 || t0 !== 1'b1) begin
      n_fail++; $display("FAIL pause_beat3 got=%0d/%b exp=3/1", b0, t0);
    end
  endtask

  task automatic test_stop_play();
    cyc();
    stop = 1'b1; play = 1'b1; cyc(); stop = 1'b0; play = 1'b0;
    n_checks++;
    if (b0 !== 8'd255 || p0 !== 1'b0 || t0 !== 1'b0) begin
      n_fail++;
      $display("FAIL stop_wins got=%0d/%b/%b exp=255/0/0", b0, p0, t0);
    end
    repeat (5) cyc();
    n_checks++;
    if (b0 !== 8'd255 || p0 !== 1'b0) begin
      n_fail++; $display("FAIL stop_idle got=%0d/%b exp=255/0", b0, p0);
    end
  endtask

  task automatic test_tempo();
    play = 1'b1; cyc(); play = 1'b0;
    repeat (4) cyc();
    cyc();
    tempo = 2'b10;
    repeat (2) cyc();
    n_checks++;
    if (b0 !== 8'd1) begin
      n_fail++; $display("FAIL tempo_no_trunc got=%0d exp=1", b0);
    end
    cyc();
    n_checks++;
    if (b0 !== 8'd2 || t0 !== 1'b1) begin
      n_fail++; $display("FAIL tempo_beat2 got=%0d/%b exp=2/1", b0, t0);
    end
    tempo = 2'b11;
    cyc();
    n_checks++;
    if (b0 !== 8'd3 || t0 !== 1'b1) begin
      n_fail++; $display("FAIL tempo_fast got=%0d/%b exp=3/1", b0, t0);
    end
    repeat (7) cyc();
    n_checks++;
    if (b0 !== 8'd3) begin
      n_fail++; $display("FAIL tempo_slow_hold got=%0d exp=3", b0);
    end
    cyc();
    tempo = 2'b00;
    n_checks++;
    if (b0 !== 8'd4 || t0 !== 1'b1) begin
      n_fail++; $display("FAIL tempo_slow_adv got=%0d/%b exp=4/1", b0, t0);
    end
    repeat (7) cyc();
    n_checks++;
    if (b0 !== 8'd4) begin
      n_fail++; $display("FAIL tempo_latched got=%0d exp=4", b0);
    end
    cyc();
    n_checks++;
    if (b0 !== 8'd5) begin
      n_fail++; $display("FAIL tempo_beat5 got=%0d exp=5", b0);
    end
    repeat (4) cyc();
    n_checks++;
    if (b0 !== 8'd255 || d0 !== 1'b1) begin
      n_fail++; $display("FAIL tempo_done got=%0d/%b exp=255/1", b0, d0);
    end
  endtask

  task automatic test_reset_pause();
    play = 1'b1; cyc(); play = 1'b0;
    repeat (5) cyc();
    pause = 1'b1; cyc(); pause = 1'b0;
    reset = 1'b1; cyc(); reset = 1'b0;
    n_checks++;
    if ({b0, t0, p0, d0} !== {8'd255, 3'b000}) begin
      n_fail++;
      $display("FAIL rst_pause got=%0d/%b/%b/%b exp=255/0/0/0", b0, t0, p0, d0);
    end
    play = 1'b1; cyc(); play = 1'b0;
    n_checks++;
    if (b0 !== 8'd0 || p0 !== 1'b1) begin
      n_fail++; $display("FAIL rst_restart got=%0d/%b exp=0/1", b0, p0);
    end
    repeat (4) cyc();
    n_checks++;
    if (b0 !== 8'd1 || t0 !== 1'b1) begin
      n_fail++; $display("FAIL rst_first_beat got=%0d/%b exp=1/1", b0, t0);
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(299) == 0);
      stop  = ($urandom_range(59) == 0);
      pause = ($urandom_range(24) == 0);
      play  = ($urandom_range(9) == 0);
      if ($urandom_range(29) == 0) tempo = 2'($urandom_range(3));
      cyc();
      n_checks++;
      if ({b0, t0, p0, d0} !== model_vec(0)) begin
        n_fail++;
        $display("FAIL rand_loop0 cyc=%0d got=%h exp=%h",
                 i, {b0, t0, p0, d0}, model_vec(0));
      end
      n_checks++;
      if ({b1, t1, p1, d1} !== model_vec(1)) begin
        n_fail++;
        $display("FAIL rand_loop1 cyc=%0d got=%h exp=%h",
                 i, {b1, t1, p1, d1}, model_vec(1));
      end
    end
    {reset, stop, pause, play} = 4'b0000;
  endtask

  initial begin
    test_reset();
    test_play_done();
    test_loop();
    test_pause();
    test_stop_play();
    test_tempo();
    test_reset_pause();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
